// File: rtl/alu_share_arb.sv
// Two-requester front end for one shared combinational ALU.
// One operation is in flight at a time: accept, execute for one cycle,
// then hold the result until the owning requester takes it.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no operation held; grant one valid requester (alternate on tie)
// EXEC  | latched operands drive the ALU; result captured at cycle end
// RESP  | result presented to the owning requester until it is consumed
module alu_share_arb #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_ctrl,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             last_grant;
  logic             lat_id;
  logic [WIDTH-1:0] lat_a;
  logic [WIDTH-1:0] lat_b;
  logic [2:0]       lat_ctrl;
  logic [WIDTH-1:0] result;
  logic [CNT_W-1:0] done_cnt;
  logic             grant_valid;
  logic             grant_id;
  logic             accept;
  logic             rsp_hs;

  // Pick a requester while idle; on a tie the one not served last wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = ~last_grant;
      end else if (req0_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b0;
      end else if (req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    state_next = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    accept     = 1'b0;
    rsp_hs     = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = grant_valid && !grant_id;
        req1_ready = grant_valid && grant_id;
        // A grant is only given to a valid requester, so it is always taken.
        if (grant_valid) begin
          accept     = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        state_next = RESP;
      end
      RESP: begin
        rsp0_valid = !lat_id;
        rsp1_valid = lat_id;
        rsp_hs     = lat_id ? rsp1_ready : rsp0_ready;
        if (rsp_hs) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand latch, result capture and completion counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_grant <= 1'b1;
      lat_id     <= 1'b0;
      lat_a      <= '0;
      lat_b      <= '0;
      lat_ctrl   <= 3'b000;
      result     <= '0;
      done_cnt   <= '0;
    end else begin
      if (accept) begin
        lat_id     <= grant_id;
        last_grant <= grant_id;
        lat_a      <= grant_id ? req1_a : req0_a;
        lat_b      <= grant_id ? req1_b : req0_b;
        lat_ctrl   <= grant_id ? req1_ctrl : req0_ctrl;
      end
      if (state == EXEC) begin
        result <= alu_result;
      end
      if (rsp_hs) begin
        done_cnt <= done_cnt + CNT_W'(1);
      end
    end
  end

  // The ALU inputs come straight from the latch, so they only move on accept.
  assign alu_a       = lat_a;
  assign alu_b       = lat_b;
  assign alu_control = lat_ctrl;
  assign rsp_result  = result;
  assign busy        = (state != IDLE);
  assign ops_done    = done_cnt;

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_share_arb;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_ctrl, req1_ctrl;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp_result;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_control;
  logic        busy;
  logic [3:0]  ops_done;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  alu_share_arb #(.WIDTH(32), .CNT_W(4)) dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result),
    .busy(busy), .ops_done(ops_done)
  );

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] c);
    case (c)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a ^ b;
      3'd3: return a | b;
      3'd4: return a & b;
      3'd5: return a << b[4:0];
      3'd6: return a >> b[4:0];
      default: return (a < b) ? 32'd1 : 32'd0;
    endcase
  endfunction

  // The shared ALU lives in the bench.
  assign alu_result = alu_fn(alu_a, alu_b, alu_control);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an outstanding operation with an age counted in clock edges since accept.
  bit          m_have = 1'b0;
  int          m_age  = 0;
  bit          m_last = 1'b1;
  bit          m_id   = 1'b0;
  logic [31:0] m_a = '0, m_b = '0, m_res = '0;
  logic [2:0]  m_c = '0;
  logic [3:0]  m_done = '0;
  bit          e_r0, e_r1, e_v0, e_v1;

  always @(negedge clk) begin
    if (check_en) begin
      e_r0 = !m_have && req0_valid && (!req1_valid || m_last);
      e_r1 = !m_have && req1_valid && (!req0_valid || !m_last);
      e_v0 = m_have && (m_age >= 2) && !m_id;
      e_v1 = m_have && (m_age >= 2) && m_id;
      chk("m_req0_ready", req0_ready, e_r0);
      chk("m_req1_ready", req1_ready, e_r1);
      chk("m_rsp0_valid", rsp0_valid, e_v0);
      chk("m_rsp1_valid", rsp1_valid, e_v1);
      chk("m_busy", busy, m_have);
      chk("m_rsp_result", rsp_result, m_res);
      chk("m_alu_a", alu_a, m_a);
      chk("m_alu_b", alu_b, m_b);
      chk("m_alu_control", alu_control, m_c);
      chk("m_ops_done", ops_done, m_done);
      if (!resetn) begin
        m_have = 0; m_age = 0; m_last = 1; m_id = 0;
        m_a = '0; m_b = '0; m_c = '0; m_res = '0; m_done = '0;
      end else if (!m_have) begin
        if (e_r0 || e_r1) begin
          m_have = 1; m_age = 1; m_id = e_r1; m_last = e_r1;
          m_a = e_r1 ? req1_a : req0_a;
          m_b = e_r1 ? req1_b : req0_b;
          m_c = e_r1 ? req1_ctrl : req0_ctrl;
        end
      end else if (m_age == 1) begin
        m_res = alu_fn(m_a, m_b, m_c);
        m_age = 2;
      end else if (m_id ? rsp1_ready : rsp0_ready) begin
        m_have = 0;
        m_done = m_done + 4'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
  endtask

  task automatic do_reset();
    resetn = 0;
    tick();
    tick();
    resetn = 1;
  endtask

  task automatic wait_rsp(output int which);
    which = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid) begin
        which = rsp1_valid ? 1 : 0;
        return;
      end
      tick();
    end
    total++;
    bad++;
    $display("FAIL rsp_wait: no response within 20 cycles at %0t", $time);
  endtask

  task automatic run_op(input bit id, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] c, output logic [31:0] res);
    int w;
    if (id) begin
      req1_valid = 1; req1_a = a; req1_b = b; req1_ctrl = c; rsp1_ready = 1;
    end else begin
      req0_valid = 1; req0_a = a; req0_b = b; req0_ctrl = c; rsp0_ready = 1;
    end
    tick();
    req0_valid = 0;
    req1_valid = 0;
    wait_rsp(w);
    chk("op_owner", w, id);
    res = rsp_result;
    tick();
  endtask

  initial begin
    int w;
    logic [31:0] r;
    resetn = 0;
    idle_inputs();
    req0_a = 0; req0_b = 0; req0_ctrl = 0;
    req1_a = 0; req1_b = 0; req1_ctrl = 0;
    tick();
    tick();
    check_en = 1;

    // Reset state
    @(negedge clk);
    chk("rst_ops_done", ops_done, 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_busy", busy, 0);
    do_reset();

    // Single subtract, latency T -> T+2
    req0_valid = 1; req0_a = 5; req0_b = 3; req0_ctrl = 3'b001; rsp0_ready = 1;
    @(negedge clk); chk("single_ready0", req0_ready, 1);
    tick(); req0_valid = 0;
    @(negedge clk); chk("single_busy_exec", busy, 1); chk("single_v0_t1", rsp0_valid, 0);
    tick();
    @(negedge clk); chk("single_v0_t2", rsp0_valid, 1); chk("single_result", rsp_result, 2);
    tick();
    @(negedge clk); chk("single_ops_done", ops_done, 1); chk("single_idle", busy, 0);

    // Tie: both valid continuously, grants alternate starting with requester 0
    do_reset();
    req0_valid = 1; req0_a = 7; req0_b = 1; req0_ctrl = 3'b000;
    req1_valid = 1; req1_a = 1; req1_b = 4; req1_ctrl = 3'b101;
    rsp0_ready = 1; rsp1_ready = 1;
    for (int i = 0; i < 4; i++) begin
      wait_rsp(w);
      chk("tie_owner", w, i % 2);
      chk("tie_result", rsp_result, (i % 2) ? 32'd16 : 32'd8);
      tick();
    end
    idle_inputs();

    // Backpressure on requester 1 while requester 0 waits
    req1_valid = 1; req1_a = 32'h0000F0F0; req1_b = 32'h00000FF0; req1_ctrl = 3'b010;
    tick();
    req1_valid = 0;
    req0_valid = 1; req0_a = 9; req0_b = 2; req0_ctrl = 3'b110;
    @(negedge clk); chk("bp_ready0_exec", req0_ready, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_v1_held", rsp1_valid, 1);
      chk("bp_result_stable", rsp_result, 32'h0000FF00);
      chk("bp_ready0_low", req0_ready, 0);
      tick();
    end
    rsp1_ready = 1;
    @(negedge clk); chk("bp_v1_last", rsp1_valid, 1);
    tick();
    rsp1_ready = 0;
    @(negedge clk); chk("bp_ready0_after", req0_ready, 1);
    tick();
    req0_valid = 0; rsp0_ready = 1;
    wait_rsp(w);
    chk("bp_owner0", w, 0);
    chk("bp_result0", rsp_result, 2);
    tick();
    idle_inputs();

    // Reset in the EXEC cycle aborts; requester 0 wins the next tie
    req0_valid = 1; req0_a = 1; req0_b = 1; req0_ctrl = 3'b000;
    tick();
    req0_valid = 0; resetn = 0;
    @(negedge clk); chk("mr_busy_exec", busy, 1);
    tick();
    resetn = 1;
    req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    chk("mr_busy", busy, 0);
    chk("mr_v0", rsp0_valid, 0);
    chk("mr_v1", rsp1_valid, 0);
    chk("mr_result", rsp_result, 0);
    chk("mr_ops_done", ops_done, 0);
    chk("mr_tie_ready0", req0_ready, 1);
    chk("mr_tie_ready1", req1_ready, 0);
    tick();
    idle_inputs(); rsp0_ready = 1;
    wait_rsp(w);
    tick();
    idle_inputs();

    // sltu edges
    run_op(0, 32'hFFFFFFFF, 32'd1, 3'b111, r); chk("sltu_big_a", r, 0);
    run_op(1, 32'd0, 32'hFFFFFFFF, 3'b111, r); chk("sltu_big_b", r, 1);
    idle_inputs();

    // Counter wrap with a 4-bit counter
    do_reset();
    for (int i = 0; i < 15; i++) run_op(i % 2, i, 1, 3'b000, r);
    @(negedge clk); chk("wrap_15", ops_done, 15);
    run_op(0, 32'd3, 32'd4, 3'b100, r);
    chk("wrap_last_and", r, 0);
    @(negedge clk); chk("wrap_0", ops_done, 0);
    idle_inputs();

    // Randomized traffic, occasional resets, valids that drop unaccepted
    for (int i = 0; i < 3000; i++) begin
      resetn     = ($urandom_range(0, 99) != 0);
      req0_valid = $urandom_range(0, 1);
      req1_valid = $urandom_range(0, 1);
      req0_a     = $urandom; req0_b = $urandom; req0_ctrl = 3'($urandom_range(0, 7));
      req1_a     = $urandom; req1_b = $urandom; req1_ctrl = 3'($urandom_range(0, 7));
      rsp0_ready = ($urandom_range(0, 2) == 0);
      rsp1_ready = ($urandom_range(0, 2) == 0);
      tick();
    end
    resetn = 1;
    idle_inputs();
    tick();
    tick();
    check_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
ALU_SHARE_ARB -- requirements
Module: alu_share_arb

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; all data ports below are WIDTH bits.
REQ-002 Parameter: CNT_W, 16, width of completed-operation counter.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 resetn  input  1  reset resetn, synchronous, active-low.
REQ-005 req0_valid / req1_valid  input  1  requester N presents an operation.
REQ-006 req0_ready / req1_ready  output  1  arbiter accepts requester N's operation this cycle.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands of requester N.
REQ-008 req0_ctrl / req1_ctrl  input  3  ALU opcode of requester N (000 add, 001 sub, 010 xor, 011 or, 100 and, 101 sll, 110 srl, 111 sltu).
REQ-009 rsp0_valid / rsp1_valid  output  1  result for requester N is available.
REQ-010 rsp0_ready / rsp1_ready  input  1  requester N consumes its result.
REQ-011 rsp_result  output  WIDTH  captured ALU result, shared by both response channels.
REQ-012 alu_a, alu_b  output  WIDTH  operands driven to the shared ALU.
REQ-013 alu_control  output  3  opcode driven to the shared ALU.
REQ-014 alu_result  input  WIDTH  shared ALU output, combinational from alu_a/alu_b/alu_control within the same cycle.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 ops_done  output  CNT_W  count of completed response handshakes.

Function
REQ-017 FSM states SHALL be IDLE, EXEC, RESP; one-hot or binary encoding is permitted.
REQ-018 In IDLE, grant: only one valid -> that requester; both valid -> requester != last_grant; none -> no grant.
REQ-019 reqN_ready SHALL be high only in IDLE and only for the granted requester; at most one ready high per cycle.
REQ-020 On accept (valid & ready), the arbiter SHALL latch a, b, ctrl and requester id, update last_grant to that id, and go to EXEC.
REQ-021 In EXEC (exactly one cycle), alu_a/alu_b/alu_control SHALL carry the latched operands; alu_result SHALL be registered into rsp_result at the end of the cycle; next state RESP.
REQ-022 In RESP, rspN_valid SHALL be high for the latched requester only; rsp_result SHALL remain stable until handshake.
REQ-023 RESP with rspN_ready high SHALL complete the handshake, increment ops_done (mod 2^CNT_W, wrapping), and go to IDLE; otherwise remain in RESP indefinitely.
REQ-024 Latency: accept in cycle T -> rspN_valid high in cycle T+2; minimum issue interval 3 cycles.
REQ-025 rspM_ready for the non-latched requester SHALL be ignored; reqN_valid during EXEC/RESP SHALL be ignored (ready low).
REQ-026 alu_a/alu_b/alu_control SHALL hold the last latched values outside EXEC (no spurious toggling).
REQ-027 Requesters SHALL be allowed to drop valid without being accepted; no state change results.
REQ-028 Results SHALL be exactly WIDTH bits as returned by the ALU; no sign extension or masking by the arbiter.

Reset
REQ-029 resetn low at a rising edge SHALL force: state IDLE, last_grant = 1 (requester 0 wins first tie), latched operands/ctrl/id = 0, rsp_result = 0, ops_done = 0.
REQ-030 During and after reset: reqN_ready follows REQ-019 from IDLE; rspN_valid = 0, busy = 0, alu_a = alu_b = 0, alu_control = 000.
REQ-031 Reset asserted in EXEC or RESP SHALL abort the operation; no response is delivered and ops_done does not increment.

Verification
REQ-032 Single op: req0 a=5, b=3, ctrl=001, rsp0_ready=1 -> req0_ready in T, rsp0_valid in T+2 with rsp_result=2, ops_done=1.
REQ-033 Tie: both valid continuously after reset, req0 ctrl=000 (7+1), req1 ctrl=101 (1<<4) -> grants alternate 0,1,0,1; results 8 and 16 routed to correct rspN_valid.
REQ-034 Backpressure: rsp1_ready low for 5 cycles, req0 valid meanwhile -> rsp1_valid held, rsp_result stable, req0_ready low until RESP exits.
REQ-035 Wrap: preload by running 2^CNT_W ops (or CNT_W=4 build, 16 ops) -> ops_done wraps to 0.
REQ-036 Mid-op reset: resetn low in EXEC cycle -> next cycle busy=0, rsp0/1_valid=0, rsp_result=0, ops_done unchanged-to-0, req0 wins next tie.
REQ-037 sltu edge: a=0xFFFFFFFF, b=1, ctrl=111 -> rsp_result=0; a=0, b=0xFFFFFFFF -> rsp_result=1.
